// File: rtl/spi_slave_pkg.sv
// Shared definitions for the SPI slave core.
// Contents: FSM state enum, slot register addresses, rd_data bit positions
// and the packed mode (ctrl) payload.
package spi_slave_pkg;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned CNT_W  = 3;
  localparam int unsigned ADDR_W = 5;
  localparam int unsigned REG_W  = 32;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    XFER = 1'b1
  } state_e;

  localparam logic [ADDR_W-1:0] ADDR_TX   = 5'h01;
  localparam logic [ADDR_W-1:0] ADDR_CTRL = 5'h02;
  localparam logic [ADDR_W-1:0] ADDR_CLR  = 5'h03;

  localparam int unsigned RD_RX_VALID_BIT = 8;
  localparam int unsigned RD_OVERRUN_BIT  = 9;
  localparam int unsigned RD_TX_EMPTY_BIT = 10;
  localparam int unsigned RD_BUSY_BIT     = 11;

  // SPI mode as written through the ctrl register: bit1 = cpha, bit0 = cpol
  typedef struct packed {
    logic cpha;
    logic cpol;
  } ctrl_t;

endpackage

// File: rtl/spi_slave_sync.sv
// Synchronizers for the asynchronous SPI pins plus SCLK / SS_n edge pulses.
// Ports:
//   clk, reset_n                 system clock, async active-low reset
//   spi_sclk, spi_ss_n, spi_mosi raw pins from the external master
//   sclk_rise_c, sclk_fall_c     one-cycle pulses on synchronized SCLK edges
//   ss_fall_c, ss_rise_c         one-cycle pulses on synchronized SS_n edges
//   mosi_s                       synchronized MOSI (same latency as SCLK)
module spi_slave_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic spi_sclk,
  input  logic spi_ss_n,
  input  logic spi_mosi,
  output logic sclk_rise_c,
  output logic sclk_fall_c,
  output logic ss_fall_c,
  output logic ss_rise_c,
  output logic mosi_s
);

  logic [SYNC_STAGES-1:0] sclk_q;
  logic [SYNC_STAGES-1:0] ss_q;
  logic [SYNC_STAGES-1:0] mosi_q;
  logic                   sclk_prev_q;
  logic                   ss_prev_q;

  // Shift chains; SCLK resets to the mode-0 idle level, SS_n to deselected
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sclk_q      <= '0;
      ss_q        <= '1;
      mosi_q      <= '0;
      sclk_prev_q <= 1'b0;
      ss_prev_q   <= 1'b1;
    end else begin
      sclk_q      <= {sclk_q[SYNC_STAGES-2:0], spi_sclk};
      ss_q        <= {ss_q[SYNC_STAGES-2:0], spi_ss_n};
      mosi_q      <= {mosi_q[SYNC_STAGES-2:0], spi_mosi};
      sclk_prev_q <= sclk_q[SYNC_STAGES-1];
      ss_prev_q   <= ss_q[SYNC_STAGES-1];
    end
  end

  assign sclk_rise_c = sclk_q[SYNC_STAGES-1] & ~sclk_prev_q;
  assign sclk_fall_c = ~sclk_q[SYNC_STAGES-1] & sclk_prev_q;
  assign ss_fall_c   = ~ss_q[SYNC_STAGES-1] & ss_prev_q;
  assign ss_rise_c   = ss_q[SYNC_STAGES-1] & ~ss_prev_q;
  assign mosi_s      = mosi_q[SYNC_STAGES-1];

endmodule

// File: rtl/spi_slave_core.sv
// SPI slave (modes 0..3, MSB first, 8-bit) with a small slot register interface.
// Ports:
//   clk, reset_n           system clock, async active-low reset
//   cs/read/write/reg_addr slot access; writes to 0x01 tx, 0x02 ctrl, 0x03 clear
//   wr_data, rd_data       slot data; rd_data is a status/rx word for any address
//   spi_sclk/ss_n/mosi     pins from the master (asynchronous to clk)
//   spi_miso, spi_miso_oe  serial data to the master and its pad enable
module spi_slave_core
  import spi_slave_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cs,
  input  logic              read,
  input  logic              write,
  input  logic [ADDR_W-1:0] reg_addr,
  input  logic [REG_W-1:0]  wr_data,
  output logic [REG_W-1:0]  rd_data,
  input  logic              spi_sclk,
  input  logic              spi_ss_n,
  input  logic              spi_mosi,
  output logic              spi_miso,
  output logic              spi_miso_oe
);

  logic sclk_rise_c, sclk_fall_c, ss_fall_c, ss_rise_c, mosi_s;

  spi_slave_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk        (clk),
    .reset_n    (reset_n),
    .spi_sclk   (spi_sclk),
    .spi_ss_n   (spi_ss_n),
    .spi_mosi   (spi_mosi),
    .sclk_rise_c(sclk_rise_c),
    .sclk_fall_c(sclk_fall_c),
    .ss_fall_c  (ss_fall_c),
    .ss_rise_c  (ss_rise_c),
    .mosi_s     (mosi_s)
  );

  state_e             state_q, state_d;
  ctrl_t              ctrl_q, ctrl_d;
  ctrl_t              mode_q, mode_d;   // mode frozen at SS_n fall
  logic [DATA_W-1:0]  tx_reg_q, tx_reg_d;
  logic [DATA_W-1:0]  tx_shift_q, tx_shift_d;
  logic [DATA_W-1:0]  rx_shift_q, rx_shift_d;
  logic [DATA_W-1:0]  rx_data_q, rx_data_d;
  logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic               rx_valid_q, rx_valid_d;
  logic               overrun_q, overrun_d;
  logic               tx_empty_q, tx_empty_d;
  logic               miso_q, miso_d;

  logic wr_c, lead_c, trail_c, sample_c, shift_c;
  logic unused_c;

  assign unused_c = ^{read, wr_data[REG_W-1:DATA_W]};

  assign wr_c     = cs & write;
  assign lead_c   = mode_q.cpol ? sclk_fall_c : sclk_rise_c;
  assign trail_c  = mode_q.cpol ? sclk_rise_c : sclk_fall_c;
  assign sample_c = mode_q.cpha ? trail_c : lead_c;
  assign shift_c  = mode_q.cpha ? lead_c : trail_c;

  // State and datapath registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      ctrl_q     <= '0;
      mode_q     <= '0;
      tx_reg_q   <= '0;
      tx_shift_q <= '0;
      rx_shift_q <= '0;
      rx_data_q  <= '0;
      bit_cnt_q  <= '0;
      rx_valid_q <= 1'b0;
      overrun_q  <= 1'b0;
      tx_empty_q <= 1'b1;
      miso_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      ctrl_q     <= ctrl_d;
      mode_q     <= mode_d;
      tx_reg_q   <= tx_reg_d;
      tx_shift_q <= tx_shift_d;
      rx_shift_q <= rx_shift_d;
      rx_data_q  <= rx_data_d;
      bit_cnt_q  <= bit_cnt_d;
      rx_valid_q <= rx_valid_d;
      overrun_q  <= overrun_d;
      tx_empty_q <= tx_empty_d;
      miso_q     <= miso_d;
    end
  end

  // Next-state: flag clears first so that byte-completion sets override them,
  // and tx writes last so a fresh byte is never marked empty by a same-cycle load
  always_comb begin
    state_d    = state_q;
    ctrl_d     = ctrl_q;
    mode_d     = mode_q;
    tx_reg_d   = tx_reg_q;
    tx_shift_d = tx_shift_q;
    rx_shift_d = rx_shift_q;
    rx_data_d  = rx_data_q;
    bit_cnt_d  = bit_cnt_q;
    rx_valid_d = rx_valid_q;
    overrun_d  = overrun_q;
    tx_empty_d = tx_empty_q;
    miso_d     = miso_q;

    if (wr_c && reg_addr == ADDR_CLR) begin
      if (wr_data[0]) rx_valid_d = 1'b0;
      if (wr_data[1]) overrun_d  = 1'b0;
    end
    if (wr_c && reg_addr == ADDR_CTRL) ctrl_d = ctrl_t'(wr_data[1:0]);

    case (state_q)
      IDLE: begin
        miso_d = 1'b0;
        if (ss_fall_c) begin
          state_d    = XFER;
          mode_d     = ctrl_q;
          tx_empty_d = 1'b1;
          bit_cnt_d  = '0;
          // cpha=0 presents bit 7 immediately; the shifter then holds bits 6..0
          if (ctrl_q.cpha) begin
            tx_shift_d = tx_reg_q;
          end else begin
            tx_shift_d = {tx_reg_q[DATA_W-2:0], 1'b0};
            miso_d     = tx_reg_q[DATA_W-1];
          end
        end
      end
      XFER: begin
        if (ss_rise_c) begin
          state_d   = IDLE;
          miso_d    = 1'b0;
          bit_cnt_d = '0;
        end else begin
          if (shift_c) begin
            miso_d     = tx_shift_q[DATA_W-1];
            tx_shift_d = {tx_shift_q[DATA_W-2:0], 1'b0};
          end
          if (sample_c) begin
            rx_shift_d = {rx_shift_q[DATA_W-2:0], mosi_s};
            bit_cnt_d  = bit_cnt_q + CNT_W'(1);
            if (bit_cnt_q == CNT_W'(DATA_W - 1)) begin
              rx_data_d  = {rx_shift_q[DATA_W-2:0], mosi_s};
              rx_valid_d = 1'b1;
              if (rx_valid_q) overrun_d = 1'b1;
              bit_cnt_d  = '0;
              tx_shift_d = tx_reg_q;
              tx_empty_d = 1'b1;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (wr_c && reg_addr == ADDR_TX) begin
      tx_reg_d   = wr_data[DATA_W-1:0];
      tx_empty_d = 1'b0;
    end
  end

  // Status word, independent of reg_addr
  always_comb begin
    rd_data                  = '0;
    rd_data[DATA_W-1:0]      = rx_data_q;
    rd_data[RD_RX_VALID_BIT] = rx_valid_q;
    rd_data[RD_OVERRUN_BIT]  = overrun_q;
    rd_data[RD_TX_EMPTY_BIT] = tx_empty_q;
    rd_data[RD_BUSY_BIT]     = (state_q == XFER);
  end

  assign spi_miso    = miso_q;
  assign spi_miso_oe = (state_q == XFER);

endmodule

// File: tb/tb_spi_slave_core.sv
// Directed bench for spi_slave_core acting as the SPI master at SCLK = clk/8.
module tb_spi_slave_core;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        cs, read, write;
  logic [4:0]  reg_addr;
  logic [31:0] wr_data;
  logic [31:0] rd_data;
  logic        spi_sclk, spi_ss_n, spi_mosi;
  logic        spi_miso, spi_miso_oe;

  int   total = 0;
  int   bad   = 0;
  logic cpol_m = 1'b0;
  logic cpha_m = 1'b0;
  logic [7:0] got;

  always #5 clk = ~clk;

  spi_slave_core #(.SYNC_STAGES(2)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .cs         (cs),
    .read       (read),
    .write      (write),
    .reg_addr   (reg_addr),
    .wr_data    (wr_data),
    .rd_data    (rd_data),
    .spi_sclk   (spi_sclk),
    .spi_ss_n   (spi_ss_n),
    .spi_mosi   (spi_mosi),
    .spi_miso   (spi_miso),
    .spi_miso_oe(spi_miso_oe)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic slot_wr(input logic [4:0] a, input logic [31:0] d);
    cs = 1'b1; write = 1'b1; reg_addr = a; wr_data = d;
    @(negedge clk);
    cs = 1'b0; write = 1'b0; reg_addr = '0; wr_data = '0;
  endtask

  // m = {cpha, cpol}, the ctrl register encoding
  task automatic set_mode(input logic [1:0] m);
    slot_wr(5'h02, {30'h0, m});
    cpha_m   = m[1];
    cpol_m   = m[0];
    spi_sclk = m[0];
    tick(8);
  endtask

  task automatic ss_low();
    spi_ss_n = 1'b0;
    tick(8);
  endtask

  task automatic ss_high();
    spi_ss_n = 1'b1;
    tick(8);
  endtask

  // Master side of one byte, MSB first, 4 clk per SCLK half period.
  // clr_last issues a 0x03 rx_valid clear landing on the slave's completion cycle (mode 0).
  task automatic spi_byte(input logic [7:0] tx, input int nbits, input bit clr_last,
                          output logic [7:0] rx);
    int i;
    rx = '0;
    for (int k = 0; k < nbits; k++) begin
      i = 7 - k;
      if (!cpha_m) begin
        spi_mosi = tx[i];
        tick(4);
        spi_sclk = ~cpol_m;
        rx[i]    = spi_miso;
        if (clr_last && k == 7) begin
          tick(2);
          slot_wr(5'h03, 32'h1);
          tick(1);
        end else begin
          tick(4);
        end
        spi_sclk = cpol_m;
      end else begin
        spi_sclk = ~cpol_m;
        spi_mosi = tx[i];
        tick(4);
        spi_sclk = cpol_m;
        rx[i]    = spi_miso;
        tick(4);
      end
    end
    tick(4);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [1:0] mm;
    cs = 1'b0; read = 1'b0; write = 1'b0; reg_addr = '0; wr_data = '0;
    spi_sclk = 1'b0; spi_ss_n = 1'b1; spi_mosi = 1'b0;
    reset_n = 1'b0;
    tick(3);
    check("rst_rd", rd_data, 32'h400);
    check("rst_miso", {31'b0, spi_miso}, 32'h0);
    check("rst_oe", {31'b0, spi_miso_oe}, 32'h0);
    reset_n = 1'b1;
    tick(3);
    check("idle_rd", rd_data, 32'h400);

    // Mode 0 basic exchange
    slot_wr(5'h01, 32'hA5);
    check("m0_txload", rd_data, 32'h0);
    ss_low();
    check("m0_oe", {31'b0, spi_miso_oe}, 32'h1);
    check("m0_busy", rd_data, 32'hC00);
    spi_byte(8'h3C, 8, 1'b0, got);
    check("m0_miso", 32'(got), 32'hA5);
    check("m0_rd_sel", rd_data, 32'hD3C);
    ss_high();
    check("m0_rd", rd_data, 32'h53C);
    check("m0_idle_oe", {31'b0, spi_miso_oe}, 32'h0);
    check("m0_idle_miso", {31'b0, spi_miso}, 32'h0);
    slot_wr(5'h03, 32'h1);
    check("m0_clr", rd_data, 32'h43C);

    // Modes 1..3: SPI mode number is {cpol, cpha}
    for (int m = 1; m < 4; m++) begin
      mm = 2'(m);
      set_mode({mm[0], mm[1]});
      slot_wr(5'h01, 32'h81);
      ss_low();
      spi_byte(8'h7E, 8, 1'b0, got);
      ss_high();
      check($sformatf("mode%0d_miso", m), 32'(got), 32'h81);
      check($sformatf("mode%0d_rd", m), rd_data, 32'h57E);
      slot_wr(5'h03, 32'h1);
    end
    set_mode(2'b00);
    check("modes_clr", rd_data, 32'h47E);

    // Two bytes under one SS; tx write after load only affects the second byte
    slot_wr(5'h01, 32'h11);
    ss_low();
    slot_wr(5'h01, 32'h33);
    check("b2b_start", rd_data, 32'h87E);
    spi_byte(8'h22, 8, 1'b0, got);
    check("b2b_first", 32'(got), 32'h11);
    spi_byte(8'h44, 8, 1'b0, got);
    check("b2b_second", 32'(got), 32'h33);
    check("b2b_rd_sel", rd_data, 32'hF44);
    ss_high();
    check("b2b_rd", rd_data, 32'h744);
    slot_wr(5'h03, 32'h3);
    check("b2b_clr", rd_data, 32'h444);

    // SS released after 5 bits, then a full byte
    slot_wr(5'h01, 32'h5A);
    ss_low();
    spi_byte(8'hFF, 5, 1'b0, got);
    check("part_bits", 32'(got), 32'h58);
    ss_high();
    check("part_rd", rd_data, 32'h444);
    check("part_oe", {31'b0, spi_miso_oe}, 32'h0);
    check("part_miso", {31'b0, spi_miso}, 32'h0);
    slot_wr(5'h01, 32'hC3);
    ss_low();
    spi_byte(8'h96, 8, 1'b0, got);
    ss_high();
    check("after_part_miso", 32'(got), 32'hC3);
    check("after_part_rd", rd_data, 32'h596);
    slot_wr(5'h03, 32'h3);

    // Reset mid-byte, then a fresh transfer
    slot_wr(5'h01, 32'hE7);
    ss_low();
    spi_byte(8'h00, 4, 1'b0, got);
    reset_n = 1'b0;
    tick(1);
    check("midrst_rd", rd_data, 32'h400);
    check("midrst_oe", {31'b0, spi_miso_oe}, 32'h0);
    check("midrst_miso", {31'b0, spi_miso}, 32'h0);
    spi_ss_n = 1'b1; spi_sclk = 1'b0; spi_mosi = 1'b0;
    tick(3);
    reset_n = 1'b1;
    tick(4);
    check("postrst_rd", rd_data, 32'h400);
    slot_wr(5'h01, 32'h69);
    ss_low();
    spi_byte(8'hB4, 8, 1'b0, got);
    ss_high();
    check("postrst_miso", 32'(got), 32'h69);
    check("postrst_rd", rd_data, 32'h5B4);
    slot_wr(5'h03, 32'h3);
    check("pre_race_clr", rd_data, 32'h4B4);

    // rx_valid clear in the completion cycle: the set wins
    slot_wr(5'h01, 32'h0F);
    ss_low();
    spi_byte(8'hF0, 8, 1'b1, got);
    ss_high();
    check("race_miso", 32'(got), 32'h0F);
    check("race_rd", rd_data, 32'h5F0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
